// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM block.
// Timebase mode and count direction encodings.
package pwm_pkg;

   typedef enum logic {PWM_MODE_EDGE, PWM_MODE_CENTER} pwm_mode_e;
   typedef enum logic {PWM_DIR_UP, PWM_DIR_DOWN} pwm_dir_e;

endpackage

// File: rtl/pwm_multi_channel.sv
// One PWM channel: compare/enable shadow, comparator and
// output register driven from the shared timebase counter.
module pwm_multi_channel #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] counter,
   input  logic         load,
   input  logic         enable,
   input  logic         polarity,
   input  logic [W-1:0] cmp,
   input  logic         ch_en,
   output logic         pwm
);

   logic [W-1:0] cmp_q;
   logic         en_q;
   logic         raw;

   // Shadow compare and enable, updated only on load strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_q <= '0;
         en_q  <= 1'b0;
      end else if (load) begin
         cmp_q <= cmp;
         en_q  <= ch_en;
      end
   end

   assign raw = en_q & (counter < cmp_q);

   // Registered output; inactive level is complement of polarity
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm <= 1'b0;
      end else if (!enable) begin
         pwm <= ~polarity;
      end else begin
         pwm <= polarity ? raw : ~raw;
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned timebase with
// period/mode shadows that reload glitch-free at the boundary.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int COUNTER_WIDTH = 10,
   parameter int NUM_CH        = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable_i,
   input  logic                            step_i,
   input  logic                            mode_i,
   input  logic [COUNTER_WIDTH-1:0]        period_i,
   input  logic [NUM_CH*COUNTER_WIDTH-1:0] cmp_i,
   input  logic [NUM_CH-1:0]               ch_en_i,
   input  logic [NUM_CH-1:0]               polarity_i,
   output logic [COUNTER_WIDTH-1:0]        counter_o,
   output logic                            period_start_o,
   output logic [NUM_CH-1:0]               pwm_o
);

   localparam int W = COUNTER_WIDTH;
   localparam logic [W-1:0] ONE = 1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_nxt;
   logic [W-1:0] period_q;
   pwm_mode_e    mode_q;
   pwm_dir_e     dir_q;
   pwm_dir_e     dir_nxt;
   logic         boundary;
   logic         load;
   logic         ps_q;

   // Next count/direction for one prescaler step
   always_comb begin
      cnt_nxt = cnt_q;
      dir_nxt = dir_q;
      if (mode_q == PWM_MODE_EDGE) begin
         if (cnt_q >= period_q) begin
            cnt_nxt = '0;
         end else begin
            cnt_nxt = cnt_q + ONE;
         end
      end else if (period_q == '0) begin
         cnt_nxt = '0;
      end else if (dir_q == PWM_DIR_UP) begin
         if (cnt_q >= period_q) begin
            cnt_nxt = period_q - ONE;
            dir_nxt = PWM_DIR_DOWN;
         end else begin
            cnt_nxt = cnt_q + ONE;
         end
      end else begin
         if (cnt_q <= ONE) begin
            cnt_nxt = '0;
         end else begin
            cnt_nxt = cnt_q - ONE;
         end
      end
      if (cnt_nxt == '0) begin
         dir_nxt = PWM_DIR_UP;
      end
   end

   assign boundary = enable_i & step_i & (cnt_nxt == '0);
   assign load     = boundary | ~enable_i;

   // Timebase counter and direction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         dir_q <= PWM_DIR_UP;
      end else if (!enable_i) begin
         cnt_q <= '0;
         dir_q <= PWM_DIR_UP;
      end else if (step_i) begin
         cnt_q <= cnt_nxt;
         dir_q <= dir_nxt;
      end
   end

   // Period and mode shadows reload only at the boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_q <= '0;
         mode_q   <= PWM_MODE_EDGE;
      end else if (load) begin
         period_q <= period_i;
         mode_q   <= pwm_mode_e'(mode_i);
      end
   end

   // Period-start pulse, boundary delayed one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps_q <= 1'b0;
      end else begin
         ps_q <= boundary;
      end
   end

   assign counter_o      = cnt_q;
   assign period_start_o = ps_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      pwm_multi_channel #(.W(W)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .counter  (cnt_q),
         .load     (load),
         .enable   (enable_i),
         .polarity (polarity_i[c]),
         .cmp      (cmp_i[c*W +: W]),
         .ch_en    (ch_en_i[c]),
         .pwm      (pwm_o[c])
      );
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: phase-based reference model checked
// every cycle, plus directed literal checks and random phases.
module tb_pwm_multi;

   localparam int W = 8;
   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           enable_i = 1'b0;
   logic           step_i = 1'b1;
   logic           mode_i = 1'b0;
   logic [W-1:0]   period_i = '0;
   logic [N*W-1:0] cmp_i = '0;
   logic [N-1:0]   ch_en_i = '0;
   logic [N-1:0]   polarity_i = '0;
   logic [W-1:0]   counter_o;
   logic           period_start_o;
   logic [N-1:0]   pwm_o;

   int total = 0;
   int bad = 0;
   int sdiv = 1;
   int sc = 0;

   always #5 clk = ~clk;

   pwm_multi #(.COUNTER_WIDTH(W), .NUM_CH(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable_i       (enable_i),
      .step_i         (step_i),
      .mode_i         (mode_i),
      .period_i       (period_i),
      .cmp_i          (cmp_i),
      .ch_en_i        (ch_en_i),
      .polarity_i     (polarity_i),
      .counter_o      (counter_o),
      .period_start_o (period_start_o),
      .pwm_o          (pwm_o)
   );

   // Reference model: position k within a period of known length
   int       m_k = 0;
   int       m_p = 0;
   bit       m_mode = 0;
   int       m_cmp[N] = '{default: 0};
   bit       m_en[N] = '{default: 0};
   bit       m_ps = 0;
   bit [N-1:0] m_pwm = '0;

   function automatic int cnt_of(int k, int p, bit md);
      if (!md) return k;
      return (k <= p) ? k : 2 * p - k;
   endfunction

   function automatic int plen(int p, bit md);
      if (!md) return p + 1;
      return (p == 0) ? 1 : 2 * p;
   endfunction

   always @(posedge clk or posedge rst) begin : mdl
      int c;
      bit ld;
      bit raw;
      if (rst) begin
         m_k = 0;
         m_p = 0;
         m_mode = 0;
         m_ps = 0;
         m_pwm = '0;
         for (int i = 0; i < N; i++) begin
            m_cmp[i] = 0;
            m_en[i] = 0;
         end
      end else begin
         c = cnt_of(m_k, m_p, m_mode);
         for (int i = 0; i < N; i++) begin
            raw = m_en[i] && (c < m_cmp[i]);
            if (!enable_i) m_pwm[i] = !polarity_i[i];
            else m_pwm[i] = polarity_i[i] ? raw : !raw;
         end
         ld = 0;
         m_ps = 0;
         if (!enable_i) begin
            m_k = 0;
            ld = 1;
         end else if (step_i) begin
            m_k = (m_k + 1) % plen(m_p, m_mode);
            if (m_k == 0) begin
               ld = 1;
               m_ps = 1;
            end
         end
         if (ld) begin
            m_p = int'(period_i);
            m_mode = mode_i;
            for (int i = 0; i < N; i++) begin
               m_cmp[i] = int'(cmp_i[i*W +: W]);
               m_en[i] = ch_en_i[i];
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin : cmp_p
      logic [W-1:0] ec;
      ec = W'(cnt_of(m_k, m_p, m_mode));
      total++;
      if (counter_o !== ec || period_start_o !== m_ps || pwm_o !== m_pwm) begin
         bad++;
         $display("FAIL model t=%0t cnt=%0d want %0d ps=%b want %b pwm=%b want %b",
                  $time, counter_o, ec, period_start_o, m_ps, pwm_o, m_pwm);
      end
   end

   task automatic chk(string nm, int got, int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sc++;
      step_i = (sdiv <= 1) ? 1'b1 : ((sc % sdiv) == 0);
   endtask

   task automatic wait_ps(string nm);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!period_start_o && n < 600);
      if (!period_start_o) begin
         total++;
         bad++;
         $display("FAIL %s timeout waiting period_start", nm);
      end
   endtask

   task automatic wait_cnt(string nm, int v);
      int n = 0;
      do begin
         tick();
         n++;
      end while (int'(counter_o) != v && n < 600);
      if (int'(counter_o) != v) begin
         total++;
         bad++;
         $display("FAIL %s timeout waiting counter=%0d", nm, v);
      end
   endtask

   task automatic set_cmp(int c, int v);
      cmp_i[c*W +: W] = W'(v);
   endtask

   initial begin
      int h0, h1, psc, badc, mx;
      int seq[8];
      seq = '{0, 1, 2, 3, 4, 3, 2, 1};

      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("rst_cnt", int'(counter_o), 0);
      chk("rst_pwm", int'(pwm_o), 0);
      chk("rst_ps", int'(period_start_o), 0);

      // 1: edge, P=9, cmp={0,3}
      period_i = 8'd9;
      set_cmp(0, 3);
      set_cmp(1, 0);
      ch_en_i = 2'b11;
      polarity_i = 2'b11;
      @(negedge clk);
      rst = 1'b0;
      tick();
      enable_i = 1'b1;
      wait_ps("t1");
      h0 = 0; h1 = 0; psc = 0; badc = 0;
      for (int i = 0; i < 20; i++) begin
         h0 += int'(pwm_o[0]);
         h1 += int'(pwm_o[1]);
         psc += int'(period_start_o);
         if (period_start_o && counter_o != 0) badc++;
         tick();
      end
      chk("t1_duty0", h0, 6);
      chk("t1_duty1", h1, 0);
      chk("t1_ps", psc, 2);
      chk("t1_ps_at0", badc, 0);

      // 2: center, P=4, cmp0=2
      mode_i = 1'b1;
      period_i = 8'd4;
      set_cmp(0, 2);
      wait_ps("t2");
      h0 = 0; psc = 0;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) chk($sformatf("t2_cnt%0d", i), int'(counter_o), seq[i]);
         if (i >= 1) begin
            h0 += int'(pwm_o[0]);
            psc += int'(period_start_o);
         end
         if (i == 8) chk("t2_ps_end", int'(period_start_o), 1);
         if (i < 8) tick();
      end
      chk("t2_duty", h0, 3);
      chk("t2_ps", psc, 1);

      // 3: shadow update mid-period
      mode_i = 1'b0;
      period_i = 8'd9;
      set_cmp(0, 3);
      wait_ps("t3a");
      wait_cnt("t3", 5);
      period_i = 8'd4;
      set_cmp(0, 7);
      mx = 5;
      begin
         int n = 0;
         do begin
            tick();
            n++;
            if (int'(counter_o) > mx) mx = int'(counter_o);
         end while (!period_start_o && n < 50);
      end
      chk("t3_maxcnt", mx, 9);
      h0 = 0; psc = 0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         h0 += int'(pwm_o[0]);
         if (i < 5) psc += int'(period_start_o);
         else chk("t3_ps5", int'(period_start_o), 1);
      end
      chk("t3_duty", h0, 5);
      chk("t3_ps_mid", psc, 0);

      // 4: prescaled steps every 3rd cycle
      period_i = 8'd3;
      set_cmp(0, 2);
      wait_ps("t4a");
      sdiv = 3;
      wait_ps("t4b");
      h0 = 0; psc = 0;
      for (int i = 0; i < 12; i++) begin
         h0 += int'(pwm_o[0]);
         psc += int'(period_start_o);
         tick();
      end
      chk("t4_duty", h0, 6);
      chk("t4_ps", psc, 1);
      sdiv = 1;

      // 5: live polarity, shadowed channel enable, cmp=0 pol=0
      period_i = 8'd9;
      set_cmp(0, 4);
      set_cmp(1, 6);
      wait_ps("t5a");
      wait_ps("t5b");
      tick();
      tick();
      polarity_i[0] = 1'b0;
      tick();
      chk("t5_pol_live", int'(pwm_o[0]), 0);
      ch_en_i = 2'b01;
      tick();
      chk("t5_en_held", int'(pwm_o[1]), 1);
      wait_ps("t5c");
      tick();
      chk("t5_en_off", int'(pwm_o[1]), 0);
      set_cmp(0, 0);
      wait_ps("t5d");
      h0 = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         h0 += int'(pwm_o[0]);
      end
      chk("t5_cmp0_pol0", h0, 10);

      // 6: asynchronous reset mid-period
      polarity_i = 2'b11;
      ch_en_i = 2'b11;
      set_cmp(0, 9);
      wait_ps("t6a");
      wait_ps("t6b");
      wait_cnt("t6", 6);
      chk("t6_pre_pwm", int'(pwm_o[0]), 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_cnt", int'(counter_o), 0);
      chk("t6_pwm", int'(pwm_o), 0);
      chk("t6_ps", int'(period_start_o), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("t6_rel_cnt", int'(counter_o), 0);
      chk("t6_rel_ps", int'(period_start_o), 1);
      tick();
      chk("t6_run_cnt", int'(counter_o), 1);

      // Random phases against the model
      for (int r = 0; r < 40; r++) begin
         mode_i = 1'($urandom_range(0, 1));
         period_i = W'($urandom_range(0, 12));
         set_cmp(0, int'($urandom_range(0, 14)));
         set_cmp(1, int'($urandom_range(0, 14)));
         ch_en_i = N'($urandom_range(0, 3));
         polarity_i = N'($urandom_range(0, 3));
         enable_i = ($urandom_range(0, 9) != 0);
         sdiv = int'($urandom_range(1, 3));
         repeat ($urandom_range(5, 40)) begin
            tick();
            if ($urandom_range(0, 15) == 0) polarity_i = ~polarity_i;
         end
      end
      enable_i = 1'b1;
      sdiv = 1;
      repeat (20) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator that supersedes the single-channel PWM block. All NUM_CH channels share one timebase counter. The counter runs up to a programmable period, in either edge-aligned (sawtooth) or center-aligned (triangle) mode. Period, mode, per-channel compare values and channel enables are held in shadow registers that update glitch-free at the period boundary.

Parameters:
COUNTER_WIDTH, 10, width W of the counter, period and compare values
NUM_CH, 4, number of PWM output channels (at least 1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable_i  input  1  timebase run enable; 0 holds counter at 0, shadows transparent
step_i  input  1  prescaler tick; counter advances only in cycles with step_i=1
mode_i  input  1  0 = edge-aligned, 1 = center-aligned (shadowed)
period_i  input  W  top count P (shadowed)
cmp_i  input  NUM_CH*W  per-channel compare, channel c at bits [c*W +: W] (shadowed)
ch_en_i  input  NUM_CH  per-channel enable (shadowed)
polarity_i  input  NUM_CH  per-channel active level, 1 = active-high (live, not shadowed)
counter_o  output  W  current counter register value
period_start_o  output  1  one-cycle pulse; counter has just entered 0 at a boundary
pwm_o  output  NUM_CH  registered PWM outputs

Behaviour:
- Reset (async, immediate, no clock needed): counter=0, dir=up, all shadows=0, mode=edge, period_start_o=0, pwm_o=0.
- Edge mode, with step_i=1: if counter>=period_q, counter goes to 0; otherwise counter+1. Period length is P+1 steps.
- Center mode, with step_i=1:
  - dir=up: counter<period_q gives counter+1; at counter==period_q, dir goes down and counter goes to period_q-1.
  - dir=down: counter-1; at counter==1, counter goes to 0 and dir goes up.
  - Period length is 2P steps. P=0 holds counter at 0.
- Boundary event: the cycle with step_i=1 in which the next counter value is 0. With P=0 this is every stepped cycle.
- At a boundary, period_q, mode_q, cmp_q[c] and ch_en_q[c] load from the inputs, so the new values apply from counter==0. No shadow changes at any other time.
- Mode change at a boundary: the new mode applies from counter 0 with dir=up.
- While enable_i=0: counter=0, dir=up, shadows load every cycle, period_start_o=0, pwm_o=inactive level. Counting starts on the first step after enable_i rises.
- period_start_o is registered and equals the boundary event delayed one cycle. It is high in the first cycle counter_o reads 0.
- Per-channel output (registered, 1-cycle latency): raw = ch_en_q[c] & (counter < cmp_q[c]); pwm_o[c] <= polarity_i[c] ? raw : ~raw.
  - Inactive level is the complement of the polarity.
  - cmp=0 gives 0% duty; cmp>P gives 100% duty (edge mode).
  - Compare is unsigned, full W bits, with no overflow possible.
- Counter does not move in cycles with step_i=0; outputs still re-register each cycle.
- polarity_i changes take effect on the next clock, since polarity is intentionally unshadowed.
- Counter never exceeds period_q, because period only changes when the counter is 0.

Decomposition:
- Package pwm_pkg holds:
  - typedef enum logic {PWM_MODE_EDGE, PWM_MODE_CENTER} pwm_mode_e
  - typedef enum logic {PWM_DIR_UP, PWM_DIR_DOWN} pwm_dir_e
- Sub-module pwm_multi_channel (one instance per channel via generate). It contains the cmp/ch_en shadow, the comparator and the output register.
- It takes counter, load strobe, enable and polarity as inputs.
- The top level holds the counter, direction, period/mode shadows and boundary logic.

Test Plan:
1. W=8, NUM_CH=2, edge mode, P=9, cmp={0,3}, pol=11, ch_en=11, step_i=1 -> pwm_o[0] high 3 of every 10 cycles; pwm_o[1] always 0; period_start_o every 10 cycles, coincident with counter_o=0.
2. Center mode, P=4, cmp[0]=2, step_i=1 -> counter_o cycles 0,1,2,3,4,3,2,1; pwm_o[0] high 3 of 8 cycles, 1 cycle after counter 0,1 and the down-count 1; period_start_o every 8 cycles.
3. Edge, P=9, cmp[0]=3, write cmp_i=7 and period_i=4 when counter_o=5 -> current period completes unchanged (count to 9, duty 3). From the next counter 0, period is 5 cycles and duty is 100% (cmp 7 > P 4).
4. step_i pulsed every 3rd cycle, P=3, cmp=2 -> counter_o holds between steps; pwm_o high 6 of 12 cycles; period_start_o single-cycle, every 12 cycles.
5. pol[0]=0 toggled live mid-period -> pwm_o[0] inverts the next cycle. ch_en_i[1]=0 mid-period -> pwm_o[1] unchanged until the boundary, then held at inactive level. Cover cmp=0 with pol=0 -> constant 1.
6. rst asserted asynchronously with counter_o=6 and pwm_o=1 -> counter_o=0, pwm_o=0 and period_start_o=0 without a clock edge. After release with enable_i=1, counting restarts from 0 with the currently presented inputs loaded.
